umips_fetch: RTL and testbench
==============================

Name: umips_fetch

Overview:
- Instruction-fetch stage; owns the PC and the instruction-memory request handshake.
- Produces inst_f and pc_plus_4_f for the IF/ID pipeline register.
- Tolerates variable-latency instruction memory and holds a fetched word while the pipeline stalls.
- Applies branch redirects after the delay-slot instruction, and exception flushes immediately.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- EXC_PC, 32'hBFC0_0380, PC loaded on exc_flush.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: decode cannot accept this cycle.
- exc_flush  in  1  exception: kill the current fetch and restart at EXC_PC.
- redirect  in  1  taken branch/jump resolved in decode (single-cycle pulse).
- redirect_pc  in  32  branch/jump target.
- imem_req  out  1  memory request.
- imem_addr  out  32  request address, always equal to pc_f.
- imem_ack  in  1  read done; imem_rdata valid this cycle; may be high in the same cycle imem_req rises.
- imem_rdata  in  32  instruction word.
- inst_f  out  32  instruction to IF/ID; 0 (NOP) when valid_f=0.
- pc_plus_4_f  out  32  pc_f+4, modulo 2^32.
- pc_f  out  32  address of the instruction in fetch.
- valid_f  out  1  inst_f holds a real instruction or an address-error marker.
- adel_f  out  1  pc_f is misaligned (pc_f[1:0]!=0).

Behaviour:
- States: FETCH, HOLD, DROP. On rst: state=FETCH, pc=RESET_PC, hold_buf=0, redir_pend=0. Combinational outputs settle from this state in the first cycle after reset.
- "Accept": valid_f=1 and stall=0. On accept, next pc = redir_pend ? redir_pc_q : (redirect ? redirect_pc : pc+4), and redir_pend clears.
- FETCH, aligned pc:
  - imem_req=1, imem_addr=pc.
  - If imem_ack: inst_f=imem_rdata, valid_f=1. Zero-wait memory gives one instruction per cycle.
  - If imem_ack and stall: capture rdata into hold_buf and go to HOLD; pc does not change.
  - If no ack: valid_f=0, inst_f=0; imem_req and imem_addr held stable.
- FETCH, misaligned pc:
  - imem_req=0, valid_f=1, adel_f=1, inst_f=0.
  - Accepted like a normal instruction; the hazard unit is expected to raise exc_flush.
- HOLD:
  - imem_req=0, inst_f=hold_buf, valid_f=1.
  - On !stall: accept and go to FETCH.
- DROP:
  - Entered when exc_flush arrives while a request is outstanding without ack.
  - imem_req=1 held at the old address (handshake must complete); valid_f=0.
  - On ack: data discarded, state=FETCH, pc=EXC_PC.
- redirect when not accepting this cycle: latch redir_pc_q=redirect_pc, set redir_pend=1. This preserves the delay slot, which is the instruction currently in fetch.
- redirect while redir_pend=1: the newer target overwrites.
- exc_flush has the highest priority, in any state:
  - Clears redir_pend; valid_f forced 0 that cycle.
  - FETCH with ack, misaligned FETCH, or HOLD: pc=EXC_PC, state=FETCH next cycle.
  - FETCH without ack: go to DROP.
  - DROP: stays DROP until ack.
- Simultaneous stall and redirect on an acked word: word goes to hold_buf; redirect goes to pending; the target is applied when HOLD accepts.
- pc_plus_4_f: 32'hFFFF_FFFC wraps to 0.
- rst overrides everything, including an outstanding memory request. The memory must tolerate an abandoned request.

Decomposition:
- umips_pkg holds:
  - NOP_INST=32'h0;
  - fetch state enum (FETCH, HOLD, DROP, 2-bit);
  - default RESET_PC and EXC_PC localparams.
- No sub-module. The hold buffer and redirect-pending register are a few flops inline.

Test Plan:
- Reset, zero-wait memory, stall=0: imem_addr = BFC00000, BFC00004, BFC00008 on consecutive cycles; valid_f=1 each cycle; pc_plus_4_f = BFC00004, ...
- 2-wait-state memory at pc=0x100: imem_req held 3 cycles at 0x100; valid_f=0 for 2 cycles, then 1 with the rdata; next address 0x104.
- Stall for 3 cycles on an acked word 0x2402_0005: HOLD presents 0x24020005 for 3 cycles with imem_req=0; on release the next request is pc+4.
- redirect to 0x400 while the delay slot at 0x204 waits on ack: 0x204 is delivered, then the next imem_addr is 0x400 (not 0x208).
- exc_flush during an un-acked request at 0x300: DROP holds the request until ack; the data is discarded (valid_f=0); next imem_addr = BFC00380.
- redirect_pc=0x402 accepted: next cycle imem_req=0, adel_f=1, valid_f=1, inst_f=0. Then exc_flush: pc=BFC00380, adel_f=0.

Source files
------------

// File: rtl/umips_pkg.sv
// Shared definitions for the uMIPS fetch stage: NOP encoding, default vectors and FSM states.
package umips_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_EXC_PC   = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StDrop  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/umips_fetch.sv
// Instruction-fetch stage: owns the PC, the imem handshake, a one-word hold buffer
// for pipeline stalls and a pending-redirect register that preserves the delay slot.
module umips_fetch
  import umips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEFAULT_EXC_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        exc_flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_f,
  output logic [31:0] pc_plus_4_f,
  output logic [31:0] pc_f,
  output logic        valid_f,
  output logic        adel_f
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic         redir_pend_q, redir_pend_d;

  logic         aligned;
  logic         accept;

  assign aligned     = (pc_q[1:0] == 2'b00);
  assign pc_f        = pc_q;
  assign imem_addr   = pc_q;
  assign pc_plus_4_f = pc_q + 32'd4;
  assign adel_f      = ~aligned;
  assign accept      = valid_f & ~stall;

  always_comb begin
    imem_req = 1'b0;
    valid_f  = 1'b0;
    inst_f   = NOP_INST;
    unique case (state_q)
      StFetch: begin
        if (aligned) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            valid_f = 1'b1;
            inst_f  = imem_rdata;
          end
        end else begin
          // Misaligned PC flows down as an address-error marker with a NOP payload.
          valid_f = 1'b1;
        end
      end
      StHold: begin
        valid_f = 1'b1;
        inst_f  = hold_q;
      end
      StDrop: begin
        imem_req = 1'b1;
      end
      default: ;
    endcase
    if (exc_flush) begin
      valid_f = 1'b0;
      inst_f  = NOP_INST;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    redir_pc_d   = redir_pc_q;
    redir_pend_d = redir_pend_q;

    if (exc_flush) begin
      redir_pend_d = 1'b0;
      // An un-acked request must still complete, so park in DROP until the ack.
      if (((state_q == StFetch) && aligned && !imem_ack) ||
          ((state_q == StDrop) && !imem_ack)) begin
        state_d = StDrop;
      end else begin
        state_d = StFetch;
        pc_d    = EXC_PC;
      end
    end else if (state_q == StDrop) begin
      if (imem_ack) begin
        state_d = StFetch;
        pc_d    = EXC_PC;
      end
    end else if (accept) begin
      state_d      = StFetch;
      redir_pend_d = 1'b0;
      if (redir_pend_q) begin
        pc_d = redir_pc_q;
      end else if (redirect) begin
        pc_d = redirect_pc;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else begin
      if (redirect) begin
        redir_pend_d = 1'b1;
        redir_pc_d   = redirect_pc;
      end
      if ((state_q == StFetch) && aligned && imem_ack && stall) begin
        state_d = StHold;
        hold_d  = imem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      hold_q       <= NOP_INST;
      redir_pc_q   <= 32'h0;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      redir_pc_q   <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
    end
  end

endmodule

// File: tb/tb_umips_fetch.sv
// Directed table-driven bench for umips_fetch: one row per cycle of inputs and expected outputs.
module tb_umips_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        exc_flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_f;
  logic [31:0] pc_plus_4_f;
  logic [31:0] pc_f;
  logic        valid_f;
  logic        adel_f;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  umips_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .exc_flush   (exc_flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_f      (inst_f),
    .pc_plus_4_f (pc_plus_4_f),
    .pc_f        (pc_f),
    .valid_f     (valid_f),
    .adel_f      (adel_f)
  );

  typedef struct {
    logic        stall;
    logic        exc;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_p4;
    logic        e_valid;
    logic [31:0] e_inst;
    logic        e_adel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic ex, input logic rd, input logic [31:0] rpc,
                     input logic ack, input logic [31:0] rdata, input logic e_req,
                     input logic [31:0] e_addr, input logic [31:0] e_p4, input logic e_valid,
                     input logic [31:0] e_inst, input logic e_adel);
    vec_t v;
    v.stall = st; v.exc = ex; v.redir = rd; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_p4 = e_p4; v.e_valid = e_valid;
    v.e_inst = e_inst; v.e_adel = e_adel;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_row(input string tag, input vec_t v);
    chk({tag, " imem_req"},    {31'b0, imem_req}, {31'b0, v.e_req});
    chk({tag, " imem_addr"},   imem_addr,         v.e_addr);
    chk({tag, " pc_f"},        pc_f,              v.e_addr);
    chk({tag, " pc_plus_4_f"}, pc_plus_4_f,       v.e_p4);
    chk({tag, " valid_f"},     {31'b0, valid_f},  {31'b0, v.e_valid});
    chk({tag, " inst_f"},      inst_f,            v.e_inst);
    chk({tag, " adel_f"},      {31'b0, adel_f},   {31'b0, v.e_adel});
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; exc_flush = v.exc; redirect = v.redir; redirect_pc = v.rpc;
    imem_ack = v.ack; imem_rdata = v.rdata;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; stall = 1'b0; exc_flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    //  st ex rd rpc           ack rdata          req addr          p4            vld inst           adel
    // Zero-wait sequential fetch from reset; branch at row 2 with BFC00008 as delay slot.
    add(0, 0, 0, 32'h0,        1, 32'h1111_0000, 1, 32'hBFC0_0000, 32'hBFC0_0004, 1, 32'h1111_0000, 0);
    add(0, 0, 0, 32'h0,        1, 32'h1111_0004, 1, 32'hBFC0_0004, 32'hBFC0_0008, 1, 32'h1111_0004, 0);
    add(0, 0, 1, 32'h100,      1, 32'h1111_0008, 1, 32'hBFC0_0008, 32'hBFC0_000C, 1, 32'h1111_0008, 0);
    // Two wait states at 0x100, then ack with stall held for 3 cycles.
    add(0, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 1, 32'h100,       32'h104,       0, 32'h0,          0);
    add(0, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 1, 32'h100,       32'h104,       0, 32'h0,          0);
    add(1, 0, 0, 32'h0,        1, 32'h2402_0005, 1, 32'h100,       32'h104,       1, 32'h2402_0005, 0);
    add(1, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 32'h100,       32'h104,       1, 32'h2402_0005, 0);
    add(1, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 0, 32'h100,       32'h104,       1, 32'h2402_0005, 0);
    add(0, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 0, 32'h100,       32'h104,       1, 32'h2402_0005, 0);
    // Released from HOLD at 0x104; jump to 0x204.
    add(0, 0, 1, 32'h204,      1, 32'h0000_0104, 1, 32'h104,       32'h108,       1, 32'h0000_0104, 0);
    // Redirect to 0x400 while delay slot at 0x204 waits on ack.
    add(0, 0, 1, 32'h400,      0, 32'hDEAD_BEEF, 1, 32'h204,       32'h208,       0, 32'h0,          0);
    add(0, 0, 0, 32'h0,        1, 32'hAAAA_0204, 1, 32'h204,       32'h208,       1, 32'hAAAA_0204, 0);
    add(0, 0, 1, 32'h300,      1, 32'h0000_0400, 1, 32'h400,       32'h404,       1, 32'h0000_0400, 0);
    // exc_flush on un-acked request at 0x300: DROP until ack, data discarded.
    add(0, 1, 0, 32'h0,        0, 32'hDEAD_BEEF, 1, 32'h300,       32'h304,       0, 32'h0,          0);
    add(0, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 1, 32'h300,       32'h304,       0, 32'h0,          0);
    add(0, 0, 0, 32'h0,        1, 32'h1234_5678, 1, 32'h300,       32'h304,       0, 32'h0,          0);
    // Exception vector, then jump to misaligned 0x402.
    add(0, 0, 1, 32'h402,      1, 32'h0000_0380, 1, 32'hBFC0_0380, 32'hBFC0_0384, 1, 32'h0000_0380, 0);
    add(1, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 0, 32'h402,       32'h406,       1, 32'h0,          1);
    add(0, 1, 0, 32'h0,        0, 32'hDEAD_BEEF, 0, 32'h402,       32'h406,       0, 32'h0,          1);
    // Back at EXC_PC; jump to top of address space to check wrap.
    add(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0381, 1, 32'hBFC0_0380, 32'hBFC0_0384, 1, 32'h0000_0381, 0);
    add(0, 0, 0, 32'h0,        1, 32'hFFFF_0000, 1, 32'hFFFF_FFFC, 32'h0,         1, 32'hFFFF_0000, 0);
    // Stall and redirect together on an acked word: target applied when HOLD accepts.
    add(1, 0, 1, 32'h500,      1, 32'hCAFE_0000, 1, 32'h0,         32'h4,         1, 32'hCAFE_0000, 0);
    add(0, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 0, 32'h0,         32'h4,         1, 32'hCAFE_0000, 0);
    // Newer pending redirect overwrites the older one.
    add(0, 0, 1, 32'h600,      0, 32'hDEAD_BEEF, 1, 32'h500,       32'h504,       0, 32'h0,          0);
    add(0, 0, 1, 32'h700,      0, 32'hDEAD_BEEF, 1, 32'h500,       32'h504,       0, 32'h0,          0);
    add(0, 0, 0, 32'h0,        1, 32'h0000_0500, 1, 32'h500,       32'h504,       1, 32'h0000_0500, 0);
    add(0, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 1, 32'h700,       32'h704,       0, 32'h0,          0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      check_row($sformatf("row%0d", i), vecs[i]);
    end

    // Reset abandons an outstanding request at 0x700 and restarts at RESET_PC.
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; exc_flush = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    v.e_req = 1'b1; v.e_addr = 32'hBFC0_0000; v.e_p4 = 32'hBFC0_0004; v.e_valid = 1'b0;
    v.e_inst = 32'h0; v.e_adel = 1'b0;
    check_row("rst_mid_req", v);

    // exc_flush while in HOLD goes straight to EXC_PC.
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA; stall = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; exc_flush = 1'b1;
    #1;
    chk("hold_flush valid_f", {31'b0, valid_f}, 32'h0);
    chk("hold_flush imem_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    exc_flush = 1'b0; stall = 1'b0;
    #1;
    chk("hold_flush imem_addr", imem_addr, 32'hBFC0_0380);
    chk("hold_flush imem_req2", {31'b0, imem_req}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
